// File: rtl/sgmii_tx_arbiter.sv
// rtl/sgmii_tx_arbiter.sv - round-robin whole-frame arbiter for the SGMII tx byte stream
//
// Shares one byte-wide transmit path between NUM_REQ frame producers. Frames
// are granted whole and round-robin. A fixed idle gap follows every frame.
// A frame longer than MAX_LEN is cut at MAX_LEN bytes. The remainder of that
// frame is then accepted and discarded, so a stuck requester cannot hold the link.
//
// Ports:
//   clock, reset        system clock, synchronous active-high reset
//   in_valid/in_data/in_last/in_ready
//                       per-requester byte streams (requester i owns in_data[8i+7:8i])
//   tx_valid/tx_data/tx_last/tx_ready
//                       merged byte stream to the SGMII driver
//   grant_id            current or most recent granted requester
//   busy                high whenever not idle
//   trunc_flag          sticky truncation indicator, cleared only by reset
//   frame_count         frames completed on tx (truncated ones included), wraps
module sgmii_tx_arbiter #(
    parameter int NUM_REQ    = 3,
    parameter int MAX_LEN    = 1518,
    parameter int IFG_CYCLES = 12
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   in_valid,
    input  logic [8*NUM_REQ-1:0] in_data,
    input  logic [NUM_REQ-1:0]   in_last,
    output logic [NUM_REQ-1:0]   in_ready,
    output logic                 tx_valid,
    output logic [7:0]           tx_data,
    output logic                 tx_last,
    input  logic                 tx_ready,
    output logic [2:0]           grant_id,
    output logic                 busy,
    output logic                 trunc_flag,
    output logic [15:0]          frame_count
);

    localparam int CW = $clog2(MAX_LEN + 1);
    localparam int GW = (IFG_CYCLES > 0) ? $clog2(IFG_CYCLES + 1) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PASS  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_GAP   = 2'd3;

    // With no gap configured, a finished frame returns straight to arbitration.
    localparam logic [1:0]    S_END    = (IFG_CYCLES > 0) ? S_GAP : S_IDLE;
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_LEN - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0);

    logic [1:0]    state_q, state_d;
    logic [2:0]    grant_q, grant_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic [GW-1:0] gap_q,   gap_d;
    logic          trunc_q, trunc_d;
    logic [15:0]   fc_q,    fc_d;

    logic          g_valid;
    logic          g_last;
    logic [7:0]    g_data;
    logic          g_ready;
    logic          win_found;
    logic [2:0]    win_idx;
    logic          at_max;

    // Granted requester's stream, selected by grant_q.
    always_comb begin
        g_valid = 1'b0;
        g_last  = 1'b0;
        g_data  = 8'h00;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q == 3'(i)) begin
                g_valid = in_valid[i];
                g_last  = in_last[i];
                g_data  = in_data[8*i +: 8];
            end
        end
    end

    // Round-robin search starting one past the last grant. Offset k = 1 is the
    // highest priority and k = NUM_REQ (the last grantee itself) the lowest.
    always_comb begin
        win_found = 1'b0;
        win_idx   = grant_q;
        for (int k = 1; k <= NUM_REQ; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!win_found && in_valid[i] &&
                    (i == ((int'(grant_q) + k) % NUM_REQ))) begin
                    win_found = 1'b1;
                    win_idx   = 3'(i);
                end
            end
        end
    end

    assign at_max = (cnt_q == CNT_LAST);

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        cnt_d    = cnt_q;
        gap_d    = gap_q;
        trunc_d  = trunc_q;
        fc_d     = fc_q;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        tx_last  = 1'b0;
        g_ready  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    grant_d = win_idx;
                    cnt_d   = '0;
                    state_d = S_PASS;
                end
            end

            S_PASS: begin
                tx_valid = g_valid;
                tx_data  = g_data;
                tx_last  = g_last | at_max;
                g_ready  = tx_ready;
                if (g_valid && tx_ready) begin
                    cnt_d = cnt_q + 1'b1;
                    if (g_last) begin
                        // A real last byte wins even when it lands exactly on MAX_LEN.
                        fc_d    = fc_q + 16'd1;
                        gap_d   = '0;
                        state_d = S_END;
                    end else if (at_max) begin
                        trunc_d = 1'b1;
                        fc_d    = fc_q + 16'd1;
                        state_d = S_DRAIN;
                    end
                end
            end

            S_DRAIN: begin
                // Swallow the rest of an over-long frame without forwarding it.
                g_ready = 1'b1;
                if (g_valid && g_last) begin
                    gap_d   = '0;
                    state_d = S_END;
                end
            end

            default: begin
                if (gap_q == GAP_LAST) begin
                    gap_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        in_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q == 3'(i)) begin
                in_ready[i] = g_ready;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            // Parking the grant on the last index makes requester 0 first after reset.
            grant_q <= 3'(NUM_REQ - 1);
            cnt_q   <= '0;
            gap_q   <= '0;
            trunc_q <= 1'b0;
            fc_q    <= 16'd0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            trunc_q <= trunc_d;
            fc_q    <= fc_d;
        end
    end

    assign grant_id    = grant_q;
    assign busy        = (state_q != S_IDLE);
    assign trunc_flag  = trunc_q;
    assign frame_count = fc_q;

endmodule

// File: tb/tb_sgmii_tx_arbiter.sv
// tb/tb_sgmii_tx_arbiter.sv - self-checking bench for sgmii_tx_arbiter
module tb_sgmii_tx_arbiter;

    localparam int NR  = 3;
    localparam int ML  = 8;
    localparam int IFG = 12;

    logic          clock = 1'b0;
    logic          reset;
    logic [NR-1:0] in_valid;
    logic [8*NR-1:0] in_data;
    logic [NR-1:0] in_last;
    logic [NR-1:0] in_ready;
    logic          tx_valid;
    logic [7:0]    tx_data;
    logic          tx_last;
    logic          tx_ready;
    logic [2:0]    grant_id;
    logic          busy;
    logic          trunc_flag;
    logic [15:0]   frame_count;

    sgmii_tx_arbiter #(.NUM_REQ(NR), .MAX_LEN(ML), .IFG_CYCLES(IFG)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_last(tx_last), .tx_ready(tx_ready),
        .grant_id(grant_id), .busy(busy), .trunc_flag(trunc_flag), .frame_count(frame_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [2:0]  v;
        logic [23:0] d;
        logic [2:0]  l;
        logic        rdy;
        logic        e_valid;
        logic [7:0]  e_data;
        logic        e_last;
        logic [2:0]  e_ready;
        logic        e_busy;
        logic [2:0]  e_grant;
    } vec_t;

    vec_t tbl [18];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    int         src_left [NR];
    int         src_len  [NR];
    int         src_pos  [NR];
    logic [7:0] src_base [NR];
    bit         src_mode;

    logic [7:0] tx_b [$];
    bit         tx_l [$];
    int         tx_c [$];
    logic [2:0] tx_g [$];
    int         drained;
    int         lasts;
    int         fall_cyc;
    bit         prev_busy;
    bit         held_pend;
    logic [7:0] held_data;

    function automatic vec_t mk(input logic [2:0] v, input logic [23:0] d, input logic [2:0] l,
                                input logic rdy, input logic ev, input logic [7:0] ed,
                                input logic el, input logic [2:0] er, input logic eb,
                                input logic [2:0] eg);
        vec_t r;
        r.v = v; r.d = d; r.l = l; r.rdy = rdy;
        r.e_valid = ev; r.e_data = ed; r.e_last = el; r.e_ready = er;
        r.e_busy = eb; r.e_grant = eg;
        return r;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive_src();
        for (int i = 0; i < NR; i++) begin
            in_valid[i]       = (src_left[i] > 0);
            in_data[8*i +: 8] = src_base[i] + 8'(src_pos[i]);
            in_last[i]        = (src_pos[i] == src_len[i] - 1);
        end
    endtask

    // Record the current cycle, advance one clock, drive the next inputs.
    task automatic tick();
        logic [NR-1:0] hs;
        hs = in_valid & in_ready;
        if (tx_valid && tx_ready) begin
            tx_b.push_back(tx_data);
            tx_l.push_back(tx_last);
            tx_c.push_back(cyc);
            tx_g.push_back(grant_id);
            if (tx_last) lasts++;
        end
        if (busy && !tx_valid && hs != 0) drained++;
        if (prev_busy && !busy && fall_cyc < 0) fall_cyc = cyc;
        prev_busy = busy;
        @(posedge clock);
        if (src_mode) begin
            for (int i = 0; i < NR; i++) begin
                if (hs[i]) begin
                    if (src_pos[i] == src_len[i] - 1) begin
                        src_pos[i]  = 0;
                        src_left[i] = src_left[i] - 1;
                    end else begin
                        src_pos[i] = src_pos[i] + 1;
                    end
                end
            end
        end
        cyc++;
        @(negedge clock);
        if (src_mode) drive_src();
        #1;
    endtask

    task automatic clear_log();
        tx_b.delete(); tx_l.delete(); tx_c.delete(); tx_g.delete();
        drained = 0; lasts = 0; fall_cyc = -1; prev_busy = 1'b0;
    endtask

    task automatic clear_src();
        for (int i = 0; i < NR; i++) begin
            src_left[i] = 0; src_len[i] = 1; src_pos[i] = 0; src_base[i] = 8'h00;
        end
    endtask

    task automatic do_reset();
        src_mode = 1'b0;
        clear_src();
        in_valid = '0; in_data = '0; in_last = '0; tx_ready = 1'b1;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        clear_log();
    endtask

    task automatic start_src();
        src_mode = 1'b1;
        drive_src();
        #1;
    endtask

    task automatic run_until(input int n_last, input int budget, input string name);
        int k;
        k = 0;
        while (lasts < n_last && k < budget) begin
            tick();
            k++;
        end
        check({name, " frame end within budget"}, int'(lasts >= n_last), 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " tx_valid"}, tx_valid, 0);
        check({tag, " tx_data"}, tx_data, 0);
        check({tag, " tx_last"}, tx_last, 0);
        check({tag, " in_ready"}, in_ready, 0);
        check({tag, " grant_id"}, grant_id, NR - 1);
        check({tag, " busy"}, busy, 0);
        check({tag, " trunc_flag"}, trunc_flag, 0);
        check({tag, " frame_count"}, frame_count, 0);
    endtask

    initial begin
        // Single frame from requester 0: one arbitration row, four data rows,
        // twelve gap rows, then idle.
        tbl[0] = mk(3'b001, 24'h0000A1, 3'b000, 1'b1, 1'b0, 8'h00, 1'b0, 3'b000, 1'b0, 3'd2);
        for (int r = 1; r <= 4; r++) begin
            tbl[r] = mk(3'b001, {16'h0, 8'hA0 + 8'(r)}, (r == 4) ? 3'b001 : 3'b000, 1'b1,
                        1'b1, 8'hA0 + 8'(r), (r == 4), 3'b001, 1'b1, 3'd0);
        end
        for (int r = 5; r <= 16; r++) begin
            tbl[r] = mk(3'b000, 24'h0, 3'b000, 1'b1, 1'b0, 8'h00, 1'b0, 3'b000, 1'b1, 3'd0);
        end
        tbl[17] = mk(3'b000, 24'h0, 3'b000, 1'b1, 1'b0, 8'h00, 1'b0, 3'b000, 1'b0, 3'd0);

        reset = 1'b1; in_valid = '0; in_data = '0; in_last = '0; tx_ready = 1'b1;
        clear_src();
        clear_log();
        #1;

        // Reset state.
        do_reset();
        check_reset_outputs("reset");

        // Table-driven single frame.
        for (int r = 0; r < 18; r++) begin
            in_valid = tbl[r].v; in_data = tbl[r].d; in_last = tbl[r].l; tx_ready = tbl[r].rdy;
            #1;
            check($sformatf("tbl[%0d] tx_valid", r), tx_valid, tbl[r].e_valid);
            if (tbl[r].e_valid) begin
                check($sformatf("tbl[%0d] tx_data", r), tx_data, tbl[r].e_data);
                check($sformatf("tbl[%0d] tx_last", r), tx_last, tbl[r].e_last);
            end
            check($sformatf("tbl[%0d] in_ready", r), in_ready, tbl[r].e_ready);
            check($sformatf("tbl[%0d] busy", r), busy, tbl[r].e_busy);
            check($sformatf("tbl[%0d] grant_id", r), grant_id, tbl[r].e_grant);
            tick();
        end
        check("single frame_count", frame_count, 1);

        // Round-robin: three requesters with two 2-byte frames each.
        do_reset();
        for (int i = 0; i < NR; i++) begin
            src_left[i] = 2; src_len[i] = 2; src_pos[i] = 0; src_base[i] = 8'h10 * 8'(i + 1);
        end
        start_src();
        run_until(6, 300, "rr");
        check("rr byte count", tx_b.size(), 12);
        if (tx_b.size() >= 12) begin
            for (int k = 0; k < 6; k++) begin
                check($sformatf("rr frame %0d grant", k), tx_g[2*k], k % 3);
                check($sformatf("rr frame %0d byte0", k), tx_b[2*k], 8'h10 * (k % 3 + 1));
                check($sformatf("rr frame %0d byte1", k), tx_b[2*k+1], 8'h10 * (k % 3 + 1) + 1);
                check($sformatf("rr frame %0d last", k), int'(tx_l[2*k+1]) * 2 + int'(tx_l[2*k]), 2);
                if (k > 0) begin
                    check($sformatf("rr frame %0d spacing", k), tx_c[2*k] - tx_c[2*k-1], IFG + 2);
                end
            end
        end
        check("rr frame_count", frame_count, 6);

        // Backpressure: tx_ready toggles during a 3-byte frame from requester 1.
        do_reset();
        src_left[1] = 1; src_len[1] = 3; src_base[1] = 8'h50;
        start_src();
        held_pend = 1'b0;
        held_data = 8'h00;
        for (int k = 0; k < 16; k++) begin
            tx_ready = (k % 2 == 0);
            #1;
            if (tx_valid) begin
                check($sformatf("bp in_ready c%0d", k), in_ready, tx_ready ? 3'b010 : 3'b000);
                if (held_pend) check($sformatf("bp hold c%0d", k), tx_data, held_data);
                held_pend = !tx_ready;
                held_data = tx_data;
            end
            tick();
        end
        tx_ready = 1'b1;
        check("bp byte count", tx_b.size(), 3);
        if (tx_b.size() >= 3) begin
            for (int k = 0; k < 3; k++) begin
                check($sformatf("bp byte %0d", k), tx_b[k], 8'h50 + k);
                check($sformatf("bp last %0d", k), tx_l[k], int'(k == 2));
            end
        end

        // Truncation: 12-byte frame from requester 2 with MAX_LEN = 8.
        do_reset();
        src_left[2] = 1; src_len[2] = 12; src_base[2] = 8'h00;
        start_src();
        run_until(1, 40, "trunc");
        for (int k = 0; k < 20; k++) tick();
        check("trunc byte count", tx_b.size(), 8);
        if (tx_b.size() >= 8) begin
            for (int k = 0; k < 8; k++) begin
                check($sformatf("trunc byte %0d", k), tx_b[k], k);
                check($sformatf("trunc last %0d", k), tx_l[k], int'(k == 7));
            end
        end
        check("trunc drained bytes", drained, 4);
        check("trunc source emptied", src_left[2], 0);
        check("trunc trunc_flag", trunc_flag, 1);
        check("trunc frame_count", frame_count, 1);
        check("trunc busy after", busy, 0);

        // Boundary: exactly MAX_LEN bytes with a real last byte.
        do_reset();
        src_left[0] = 1; src_len[0] = 8; src_base[0] = 8'h80;
        start_src();
        run_until(1, 40, "bound");
        for (int k = 0; k < 16; k++) tick();
        check("bound byte count", tx_b.size(), 8);
        check("bound lasts", lasts, 1);
        if (tx_b.size() >= 8) begin
            check("bound byte 7", tx_b[7], 8'h87);
            check("bound last on byte 7", tx_l[7], 1);
            check("bound idle after gap", fall_cyc - tx_c[7], IFG + 1);
        end
        check("bound drained bytes", drained, 0);
        check("bound trunc_flag", trunc_flag, 0);
        check("bound frame_count", frame_count, 1);

        // Reset in the middle of a frame, then both 0 and 1 pending.
        do_reset();
        src_left[0] = 1; src_len[0] = 4; src_base[0] = 8'hC0;
        start_src();
        tick();
        check("rst byte0 valid", tx_valid, 1);
        check("rst byte0 data", tx_data, 8'hC0);
        tick();
        check("rst byte1 data", tx_data, 8'hC1);
        reset = 1'b1;
        tick();
        check_reset_outputs("mid-frame reset");
        clear_src();
        src_left[0] = 1; src_len[0] = 2; src_base[0] = 8'hD0;
        src_left[1] = 1; src_len[1] = 2; src_base[1] = 8'hE0;
        reset = 1'b0;
        clear_log();
        drive_src();
        #1;
        run_until(2, 80, "post-reset");
        check("post-reset byte count", tx_b.size(), 4);
        if (tx_b.size() >= 4) begin
            check("post-reset first grant", tx_g[0], 0);
            check("post-reset first byte", tx_b[0], 8'hD0);
            check("post-reset second grant", tx_g[2], 1);
            check("post-reset second byte", tx_b[2], 8'hE0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sgmii_tx_arbiter.md
Name: sgmii_tx_arbiter

Overview:
- Shares the single byte-wide transmit path of the SGMII driver between NUM_REQ frame producers, e.g. the XVC reply engine, an ARP responder and a debug/status sender.
- Grants whole frames round-robin and enforces a fixed inter-frame gap.
- Truncates any frame longer than MAX_LEN, then drains the rest of it so a stuck requester cannot lock the link.
- Sits between the requesters and the driver's tx stream input in the top-level design.

Parameters:
NUM_REQ, 3, number of requesters (2..8)
MAX_LEN, 1518, max bytes per frame before forced truncation
IFG_CYCLES, 12, idle cycles inserted after every frame end (0 allowed)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
in_valid  in  NUM_REQ  per-requester byte valid
in_data  in  8*NUM_REQ  per-requester byte; requester i uses bits [8i+7:8i]
in_last  in  NUM_REQ  per-requester last byte of frame
in_ready  out  NUM_REQ  per-requester byte accepted
tx_valid  out  1  byte valid to driver
tx_data  out  8  byte to driver
tx_last  out  1  last byte of frame to driver
tx_ready  in  1  driver accepts byte
grant_id  out  3  index of the current/last granted requester
busy  out  1  high in any state other than IDLE
trunc_flag  out  1  sticky; set on truncation, cleared only by reset
frame_count  out  16  frames completed on tx, including truncated ones; wraps at 65535->0

Behaviour:
- Transfer rule: a byte transfers when valid and ready are both high in the same cycle (in or tx side).
- Reset (synchronous, checked every cycle, overrides all states): state=IDLE, in_ready=0, tx_valid=0, tx_data=0, tx_last=0, grant_id=NUM_REQ-1, busy=0, trunc_flag=0, frame_count=0, byte counter=0, gap counter=0.
  - The grant_id reset value makes requester 0 the first priority.
- Reset during PASS: the frame is abandoned with no tx_last. The driver is reset by the same signal.
- States: IDLE, PASS, DRAIN, GAP.
- IDLE:
  - in_ready=0, tx_valid=0.
  - Searches in_valid from (grant_id+1) mod NUM_REQ upward with wrap; the first asserted index wins.
  - On a win: grant_id<=winner, byte counter<=0, next state PASS.
  - Arbitration latency is exactly 1 cycle: a request seen in cycle N can appear on tx_valid in cycle N+1 at the earliest.
  - No request: stay in IDLE.
- PASS (combinational pass-through of granted requester g=grant_id):
  - tx_valid=in_valid[g], tx_data=in_data[g], tx_last=in_last[g] OR (byte counter==MAX_LEN-1).
  - in_ready[g]=tx_ready; in_ready of all other requesters = 0.
  - Byte counter increments on each tx transfer.
  - Transfer with in_last[g]=1: frame_count++, go to GAP (or IDLE if IFG_CYCLES=0).
  - Transfer with counter==MAX_LEN-1 and in_last[g]=0: this is the truncation.
    - tx_last is forced high on that byte, trunc_flag<=1, frame_count++.
    - Next state is DRAIN.
  - When in_last[g] and counter==MAX_LEN-1 coincide, the frame is normal: no truncation, no DRAIN.
  - Requester deasserting in_valid mid-frame: tx_valid follows it low. The grant is held with no timeout.
- DRAIN:
  - tx_valid=0, in_ready[g]=1; granted bytes are discarded.
  - On in_valid[g]&in_last[g]: go to GAP (or IDLE if IFG_CYCLES=0).
- GAP:
  - tx_valid=0, in_ready=0; gap counter counts IFG_CYCLES cycles, then IDLE.
  - The next frame's first byte therefore appears at least IFG_CYCLES+1 cycles after the previous tx_last transfer.
- Width rules:
  - Byte counter width is clog2(MAX_LEN+1).
  - Gap counter width is clog2(IFG_CYCLES+1), minimum 1.
  - frame_count wraps modulo 2^16.
- grant_id updates only on a win in IDLE; it is stable for the whole frame, DRAIN and GAP.
- No requester is starved: each waiting requester is granted within NUM_REQ-1 other frames.

Test Plan:
- Single frame: req0 sends 4 bytes 0xA1..0xA4 (last on 0xA4), tx_ready=1 -> tx shows A1..A4 in cycles 1..4 after the request, tx_last on A4, frame_count=1, grant_id=0, then 12 idle GAP cycles, busy=0 on the 13th.
- Round-robin: all three requesters hold 2-byte frames continuously -> grant order 0,1,2,0,1,2, each frame separated by exactly 12 GAP cycles plus 1 arbitration cycle, frame_count=6.
- Backpressure: tx_ready toggles 1,0,1,0 during a 3-byte req1 frame -> each byte held stable on tx_data until accepted, in_ready[1] mirrors tx_ready, no byte lost or duplicated.
- Truncation with MAX_LEN=8: req2 sends 12 bytes 0x00..0x0B -> tx carries 0x00..0x07 with tx_last on 0x07; bytes 0x08..0x0B are accepted with tx_valid=0; trunc_flag=1, frame_count=1.
- Boundary with MAX_LEN=8: 8-byte frame with in_last on byte 8 -> normal end, trunc_flag stays 0, no DRAIN cycles.
- Reset mid-frame: assert reset on byte 2 of a req0 frame -> next cycle all outputs at reset values; after reset release with req1 and req0 both pending, req0 is granted first.
